fir_filter: RTL and testbench

Fixed-coefficient, direct-form FIR filter on 8-bit signed samples, clocked once per sample. It is the filtering datapath of the adaptive LMS filter. Each clock it shifts in the newest input sample and produces a registered, saturated 8-bit output. It also presents the previous output so the error/update logic downstream can use both values.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_tap.sv | 34 +++
 rtl/fir_filter.sv | 96 +++++++++
 tb/tb_fir_filter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types, widths and arithmetic helpers for the FIR datapath.
//   SAMPLE_W / COEFF_W : sample and coefficient widths (8 bits each)
//   PROD_W             : width of one coefficient * sample product
//   sample_t           : signed 8-bit sample
//   acc_width()        : accumulator width that cannot overflow for N taps
//   sat8()             : clamp a sign-extended value to the 8-bit range
package fir_pkg;

  localparam int SAMPLE_W = 8;
  localparam int COEFF_W  = 8;
  localparam int PROD_W   = SAMPLE_W + COEFF_W;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  // Each product fits in 16 bits; summing N of them needs ceil(log2 N) more.
  function automatic int acc_width(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

  // Callers sign-extend their accumulator to 32 bits before calling.
  function automatic sample_t sat8(input logic signed [31:0] v);
    if (v > 32'sd127) begin
      return sample_t'(8'h7F);
    end else if (v < -32'sd128) begin
      return sample_t'(8'h80);
    end else begin
      return sample_t'(v[SAMPLE_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/fir_tap.sv
// fir_tap: one delay-line stage plus its constant-coefficient multiplier.
//   clk    : sample clock
//   rst    : synchronous active-high reset, clears the stage
//   i_d    : value this stage takes at the next edge (previous stage or x[n])
//   o_q    : registered stage contents d[k]
//   o_prod : COEFF * i_d, the product for this tap after the coming shift
// The product is taken from the stage input, not the register, so the sum is
// formed over the delay line as it will look after this edge's shift.
module fir_tap
  import fir_pkg::*;
#(
  parameter logic signed [COEFF_W-1:0] COEFF = 8'sd1
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t i_d,
  output sample_t o_q,
  output prod_t   o_prod
);

  sample_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q    = r_q;
  assign o_prod = prod_t'(COEFF) * prod_t'(i_d);

endmodule

// File: rtl/fir_filter.sv
// fir_filter: fixed-coefficient direct-form FIR on signed 8-bit samples,
// one sample per clock, registered and saturated 8-bit output.
//   clk           : sample clock, everything updates on the rising edge
//   rst           : synchronous active-high reset, clears history
//   in_x_last     : newest sample x[n], captured every non-reset edge
//   y_0           : seed loaded into out_y_last during reset
//   out_y_last    : y[n-1], previous filter output
//   out_y_current : y[n], current filter output
// Parameters: TAPS (2..16), FRAC (fraction bits of the coefficients),
// COEFFS (packed, c[k] in bits [8k+7:8k], c[0] weights the newest sample).
module fir_filter
  import fir_pkg::*;
#(
  parameter int                         TAPS   = 4,
  parameter int                         FRAC   = 0,
  parameter logic [COEFF_W*TAPS-1:0]    COEFFS = {TAPS{8'h01}}
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t in_x_last,
  input  sample_t y_0,
  output sample_t out_y_last,
  output sample_t out_y_current
);

  localparam int ACC_W = acc_width(TAPS);
  // One spare bit so the rounding bias can never wrap the sum.
  localparam int RND_W = ACC_W + 1;

  if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
    $error("fir_filter: TAPS must be in 2..16");
  end

  sample_t w_q    [TAPS];
  prod_t   w_prod [TAPS];

  // Tap chain: stage 0 takes the new sample, stage k takes stage k-1.
  // The last stage's contents never reach the output (it only ever feeds
  // a stage that does not exist), but it is kept as part of the delay line.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    sample_t w_in;
    if (gi == 0) begin : g_first
      assign w_in = in_x_last;
    end else begin : g_rest
      assign w_in = w_q[gi-1];
    end

    fir_tap #(
      .COEFF (signed'(COEFFS[COEFF_W*gi +: COEFF_W]))
    ) u_tap (
      .clk    (clk),
      .rst    (rst),
      .i_d    (w_in),
      .o_q    (w_q[gi]),
      .o_prod (w_prod[gi])
    );
  end

  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + ACC_W'(w_prod[k]);
    end
  end

  logic signed [RND_W-1:0] w_rnd;

  // Round half up: add half an LSB of the result, then arithmetic shift.
  if (FRAC > 0) begin : g_round
    localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (FRAC - 1);
    logic signed [RND_W-1:0] w_biased;
    assign w_biased = RND_W'(w_sum) + HALF;
    assign w_rnd    = w_biased >>> FRAC;
  end else begin : g_no_round
    assign w_rnd = RND_W'(w_sum);
  end

  sample_t r_y_current;
  sample_t r_y_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_current <= '0;
      r_y_last    <= y_0;
    end else begin
      r_y_last    <= r_y_current;
      r_y_current <= sat8(32'(w_rnd));
    end
  end

  assign out_y_current = r_y_current;
  assign out_y_last    = r_y_last;

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed self-checking bench for fir_filter. Three instances
// share the stimulus: default coefficients, impulse coefficients {4,-3,2,1},
// and default coefficients with FRAC=2.
module tb_fir_filter;

  logic              clk;
  logic              rst;
  logic signed [7:0] in_x;
  logic signed [7:0] y_0;

  logic signed [7:0] last_def, cur_def;
  logic signed [7:0] last_imp, cur_imp;
  logic signed [7:0] last_rnd, cur_rnd;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fir_filter u_dut_def (
    .clk           (clk),
    .rst           (rst),
    .in_x_last     (in_x),
    .y_0           (y_0),
    .out_y_last    (last_def),
    .out_y_current (cur_def)
  );

  fir_filter #(
    .TAPS   (4),
    .FRAC   (0),
    .COEFFS ({8'sd1, 8'sd2, -8'sd3, 8'sd4})
  ) u_dut_imp (
    .clk           (clk),
    .rst           (rst),
    .in_x_last     (in_x),
    .y_0           (y_0),
    .out_y_last    (last_imp),
    .out_y_current (cur_imp)
  );

  fir_filter #(
    .TAPS (4),
    .FRAC (2)
  ) u_dut_rnd (
    .clk           (clk),
    .rst           (rst),
    .in_x_last     (in_x),
    .y_0           (y_0),
    .out_y_last    (last_rnd),
    .out_y_current (cur_rnd)
  );

  // One reset edge with the given seed; afterwards y_0 is parked on a value
  // that must never appear, since it is ignored outside reset.
  task automatic do_reset(input int seed);
    rst  = 1'b1;
    y_0  = 8'(seed);
    in_x = 8'sd55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    y_0 = 8'sd99;
  endtask

  task automatic step(input int x);
    in_x = 8'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(5);
    checks++;
    if (cur_def !== 8'sd0) begin
      failures++;
      $display("FAIL reset_cur: got %0d expected 0", cur_def);
    end
    checks++;
    if (last_def !== 8'sd5) begin
      failures++;
      $display("FAIL reset_last: got %0d expected 5", last_def);
    end
    checks++;
    if (last_imp !== 8'sd5 || cur_imp !== 8'sd0) begin
      failures++;
      $display("FAIL reset_imp: got last=%0d cur=%0d expected last=5 cur=0", last_imp, cur_imp);
    end
    $display("test_reset: seed=5 cur=%0d last=%0d", cur_def, last_def);
  endtask

  task automatic test_default_stream();
    int xs   [7] = '{2, 1, 2, 1, 2, 1, 2};
    int ecur [7] = '{2, 3, 5, 6, 6, 6, 6};
    int elast[7] = '{0, 2, 3, 5, 6, 6, 6};
    do_reset(0);
    for (int i = 0; i < 7; i++) begin
      step(xs[i]);
      checks++;
      if (cur_def !== 8'(ecur[i])) begin
        failures++;
        $display("FAIL stream_cur[%0d]: got %0d expected %0d", i, cur_def, ecur[i]);
      end
      checks++;
      if (last_def !== 8'(elast[i])) begin
        failures++;
        $display("FAIL stream_last[%0d]: got %0d expected %0d", i, last_def, elast[i]);
      end
      $display("test_default_stream: x=%0d cur=%0d last=%0d", xs[i], cur_def, last_def);
    end
  endtask

  task automatic test_saturation();
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      step(127);
      checks++;
      if (cur_def !== 8'sd127) begin
        failures++;
        $display("FAIL sat_pos[%0d]: got %0d expected 127", i, cur_def);
      end
      $display("test_saturation: x=127 cur=%0d", cur_def);
    end
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      step(-128);
      checks++;
      if (cur_def !== -8'sd128) begin
        failures++;
        $display("FAIL sat_neg[%0d]: got %0d expected -128", i, cur_def);
      end
      $display("test_saturation: x=-128 cur=%0d", cur_def);
    end
  endtask

  task automatic test_impulse();
    int xs  [5] = '{1, 0, 0, 0, 0};
    int ecur[5] = '{4, -3, 2, 1, 0};
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      step(xs[i]);
      checks++;
      if (cur_imp !== 8'(ecur[i])) begin
        failures++;
        $display("FAIL impulse[%0d]: got %0d expected %0d", i, cur_imp, ecur[i]);
      end
      $display("test_impulse: x=%0d cur=%0d", xs[i], cur_imp);
    end
  endtask

  // FRAC=2: (sum + 2) >>> 2 with an arithmetic shift.
  task automatic test_rounding();
    int epos[4] = '{0, 1, 1, 1};
    int eneg[4] = '{0, 0, -1, -1};
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (cur_rnd !== 8'(epos[i])) begin
        failures++;
        $display("FAIL round_pos[%0d]: got %0d expected %0d", i, cur_rnd, epos[i]);
      end
      $display("test_rounding: x=1 cur=%0d", cur_rnd);
    end
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      step(-1);
      checks++;
      if (cur_rnd !== 8'(eneg[i])) begin
        failures++;
        $display("FAIL round_neg[%0d]: got %0d expected %0d", i, cur_rnd, eneg[i]);
      end
      $display("test_rounding: x=-1 cur=%0d", cur_rnd);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      step(2);
    end
    checks++;
    if (cur_def !== 8'sd6) begin
      failures++;
      $display("FAIL mid_prefill: got %0d expected 6", cur_def);
    end
    do_reset(-7);
    checks++;
    if (last_def !== -8'sd7 || cur_def !== 8'sd0) begin
      failures++;
      $display("FAIL mid_reset: got last=%0d cur=%0d expected last=-7 cur=0", last_def, cur_def);
    end
    step(1);
    checks++;
    if (cur_def !== 8'sd1) begin
      failures++;
      $display("FAIL mid_first_cur: got %0d expected 1", cur_def);
    end
    checks++;
    if (last_def !== 8'sd0) begin
      failures++;
      $display("FAIL mid_first_last: got %0d expected 0", last_def);
    end
    $display("test_mid_reset: x=1 cur=%0d last=%0d", cur_def, last_def);
  endtask

  initial begin
    rst  = 1'b1;
    in_x = '0;
    y_0  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_default_stream();
    test_saturation();
    test_impulse();
    test_rounding();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
